// File: rtl/nn_pkg.sv
// nn_pkg: shared constants, result-metadata struct and FSM state encoding for
// the calc -> result-accumulator path.
//   res_meta_t   : per-neuron metadata carried alongside calc's partial sums
//   state_t      : accumulator FSM state (IDLE/ACCUM/SCALE/WRITE constants)
//   chunk_target : number of LANES-wide chunks making up one neuron
package nn_pkg;

  localparam int SUM_W  = 48;
  localparam int ACC_W  = 56;
  localparam int OUT_W  = 24;
  localparam int ADDR_W = 17;
  localparam int LANES  = 8;

  localparam int NT_W  = 17;  // neuron table pointer
  localparam int SH_W  = 5;   // shift amounts
  localparam int NIN_W = 10;  // fan-in
  localparam int NN_W  = 11;  // neuron index

  typedef struct packed {
    logic [NT_W-1:0]   neuron_table;
    logic [SH_W-1:0]   post_shift;
    logic [SH_W-1:0]   neuron_shift;
    logic [ADDR_W-1:0] oloc;
    logic [NIN_W-1:0]  ninputs;
    logic [NN_W-1:0]   neuron_number;
  } res_meta_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t SCALE = 2'd2;
  localparam state_t WRITE = 2'd3;

  // max(1, ceil(n / 2**lg2)); a zero fan-in still produces one chunk so the
  // neuron gets written.
  function automatic logic [NIN_W:0] chunk_target(input logic [NIN_W-1:0] n,
                                                   input int lg2);
    logic [NIN_W:0] c;
    c = ({1'b0, n} + (NIN_W+1)'((1 << lg2) - 1)) >> lg2;
    if (c == '0) c = (NIN_W+1)'(1);
    return c;
  endfunction

endpackage

// File: rtl/nn_shift_sat.sv
// nn_shift_sat: combinational arithmetic right shift, signed saturation to
// OUT_W and optional ReLU.
//   din   : signed IN_W value
//   shift : arithmetic right shift amount
//   dout  : saturated OUT_W result
// Optional feature macro: NN_RELU_EN -- negative saturated results become 0.
module nn_shift_sat #(
  parameter int IN_W  = 56,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0] din,
  input  logic [4:0]             shift,
  output logic [OUT_W-1:0]       dout
);

  localparam logic signed [IN_W-1:0] MAXV =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;
  logic [OUT_W-1:0]       sat;

  assign shifted = din >>> shift;

  always_comb begin
    sat = shifted[OUT_W-1:0];
    if (shifted > MAXV)      sat = MAXV[OUT_W-1:0];
    else if (shifted < MINV) sat = MINV[OUT_W-1:0];
  end

`ifdef NN_RELU_EN
  assign dout = sat[OUT_W-1] ? '0 : sat;
`else
  assign dout = sat;
`endif

endmodule

// File: rtl/nn_result_accum.sv
// nn_result_accum: receiving end of calc's pushout/stopin interface.
// Sums all chunks of a neuron, post-shifts and saturates the total, then
// writes one result to activation memory at oloc + (neuron_number << neuron_shift).
//   clk, reset     : clock, async active-high reset
//   pushin/stopout : partial-sum valid / not-ready back to calc
//   sum_in + meta  : partial sum and neuron metadata (sampled on first chunk)
//   finish_in      : last neuron of layer (sampled on first chunk)
//   wr_en/addr/data: result write, one cycle
//   done           : pulses with wr_en
//   finish_out     : pulses with wr_en when the neuron was flagged last
//   busy           : FSM not idle
//   err            : sticky protocol error (push while stalled, neuron switch)
// Optional feature macro: NN_RELU_EN (applied inside nn_shift_sat).
// ADDR_W must match nn_pkg::ADDR_W since oloc is carried in res_meta_t.
module nn_result_accum #(
  parameter int SUM_W  = 48,
  parameter int ACC_W  = 56,
  parameter int OUT_W  = 24,
  parameter int ADDR_W = 17,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pushin,
  output logic              stopout,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic [16:0]       neuron_table,
  input  logic [4:0]        post_shift,
  input  logic [4:0]        neuron_shift,
  input  logic [ADDR_W-1:0] oloc,
  input  logic [9:0]        ninputs,
  input  logic [10:0]       neuron_number,
  input  logic              finish_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data,
  output logic              done,
  output logic              finish_out,
  output logic              busy,
  output logic              err
);
  import nn_pkg::*;

  localparam int CNT_W = NIN_W + 1;
  localparam int LG2   = $clog2(LANES);

  state_t                   state;
  res_meta_t                meta_q, meta_in;
  logic                     fin_q;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt, nchunks_q, nchunks_in, cnt_inc;
  logic signed [ACC_W-1:0]  sum_ext;
  logic [OUT_W-1:0]         sat_res;
  logic [ADDR_W-1:0]        addr_calc;
  logic                     accept, same_neuron, restart;

  assign stopout = (state == SCALE) || (state == WRITE);
  assign busy    = (state != IDLE);
  assign accept  = pushin && !stopout;

  assign sum_ext = {{(ACC_W-SUM_W){sum_in[SUM_W-1]}}, sum_in};

  assign meta_in = '{neuron_table:  neuron_table,
                     post_shift:    post_shift,
                     neuron_shift:  neuron_shift,
                     oloc:          oloc,
                     ninputs:       ninputs,
                     neuron_number: neuron_number};

  assign nchunks_in  = chunk_target(ninputs, LG2);
  assign same_neuron = (neuron_number == meta_q.neuron_number);
  assign cnt_inc     = cnt + CNT_W'(1);

  // A packet for a different neuron while accumulating abandons the partial
  // and is handled exactly like the first packet of a fresh neuron.
  assign restart = accept && ((state == IDLE) || (state == ACCUM && !same_neuron));

  assign addr_calc = meta_q.oloc + (ADDR_W'(meta_q.neuron_number) << meta_q.neuron_shift);

  nn_shift_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_shift_sat (
    .din   (acc),
    .shift (meta_q.post_shift),
    .dout  (sat_res)
  );

  // Table pointer and fan-in are held for the neuron's lifetime but not
  // consumed downstream of the chunk-count latch.
  logic unused_meta;
  assign unused_meta = ^{meta_q.neuron_table, meta_q.ninputs};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      meta_q     <= '0;
      fin_q      <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      nchunks_q  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      finish_out <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      done       <= 1'b0;
      finish_out <= 1'b0;

      // calc is expected to hold the packet while stalled; a push here is lost
      if (pushin && stopout) err <= 1'b1;

      if (restart) begin
        if (state == ACCUM) err <= 1'b1;
        meta_q    <= meta_in;
        fin_q     <= finish_in;
        acc       <= sum_ext;
        cnt       <= CNT_W'(1);
        nchunks_q <= nchunks_in;
        state     <= (nchunks_in == CNT_W'(1)) ? SCALE : ACCUM;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              acc <= acc + sum_ext;
              cnt <= cnt_inc;
              if (cnt_inc == nchunks_q) state <= SCALE;
            end
          end
          SCALE: begin
            // outputs registered here so they are valid throughout WRITE
            wr_en      <= 1'b1;
            done       <= 1'b1;
            finish_out <= fin_q;
            wr_data    <= sat_res;
            wr_addr    <= addr_calc;
            state      <= WRITE;
          end
          WRITE:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_result_accum.sv
module tb_nn_result_accum;

`ifdef NN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pushin;
  logic        stopout;
  logic [47:0] sum_in;
  logic [16:0] neuron_table;
  logic [4:0]  post_shift;
  logic [4:0]  neuron_shift;
  logic [16:0] oloc;
  logic [9:0]  ninputs;
  logic [10:0] neuron_number;
  logic        finish_in;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;
  logic        done;
  logic        finish_out;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  nn_result_accum dut (
    .clk           (clk),
    .reset         (reset),
    .pushin        (pushin),
    .stopout       (stopout),
    .sum_in        (sum_in),
    .neuron_table  (neuron_table),
    .post_shift    (post_shift),
    .neuron_shift  (neuron_shift),
    .oloc          (oloc),
    .ninputs       (ninputs),
    .neuron_number (neuron_number),
    .finish_in     (finish_in),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .done          (done),
    .finish_out    (finish_out),
    .busy          (busy),
    .err           (err)
  );

  typedef struct {
    logic [16:0] addr;
    logic [23:0] data;
    logic        fin;
  } exp_t;

  typedef struct {
    int               n_in;
    int               nsum;
    logic [3:0][47:0] s;
    int               ps;
    int               ns;
    int               ol;
    int               nn;
    bit               fin;
    int               eaddr;
    int               edata;
    bit               efin;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n_in, int nsum, longint a, longint b, longint c,
                              int ps, int ns, int ol, int nn, bit fin,
                              int ea, int ed, bit ef);
    vec_t v;
    v.n_in = n_in; v.nsum = nsum;
    v.s[0] = 48'(a); v.s[1] = 48'(b); v.s[2] = 48'(c); v.s[3] = '0;
    v.ps = ps; v.ns = ns; v.ol = ol; v.nn = nn; v.fin = fin;
    v.eaddr = ea; v.edata = ed; v.efin = ef;
    return v;
  endfunction

  task automatic expect_wr(input int a, input int d, input bit f);
    exp_t e;
    e.addr = 17'(a); e.data = 24'(d); e.fin = f;
    sbq.push_back(e);
  endtask

  // Drive one packet; it is accepted at the next rising edge.
  task automatic send(input int n_in, input logic [47:0] s, input int ps, input int ns,
                      input int ol, input int nn, input bit fin);
    sum_in        = s;
    ninputs       = 10'(n_in);
    post_shift    = 5'(ps);
    neuron_shift  = 5'(ns);
    oloc          = 17'(ol);
    neuron_number = 11'(nn);
    finish_in     = fin;
    neuron_table  = 17'($urandom);
    pushin        = 1'b1;
    #1;
    chk("stopout_open", stopout, 0);
    @(posedge clk); #1;
    pushin = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 16 && sbq.size() != 0; c++) @(posedge clk);
    #1;
    chk("write_arrived", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_finish_out"}, finish_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_stopout"}, stopout, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  // Scoreboard: every write must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        n_wr++;
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", wr_addr, wr_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("done", done, 1);
          chk("finish_out", finish_out, e.fin);
        end
      end else if (done || finish_out) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_pulse: done %0b finish_out %0b without wr_en (required 0 0)", done, finish_out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(8,  1, 1000, 0, 0,                      2, 1, 'h100,   3, 0, 'h106, 250,       0);
    vecs[1] = mk(20, 3, 100, -50, 30,                    0, 0, 'h200,   7, 0, 'h207, 80,        0);
    vecs[2] = mk(8,  1, longint'(1) << 40, 0, 0,         0, 4, 'h0,     1, 0, 'h10,  'h7FFFFF,  0);
    vecs[3] = mk(8,  1, -(longint'(1) << 40), 0, 0,      0, 0, 'h20,    0, 0, 'h20,  'h800000,  0);
    vecs[4] = mk(8,  1, -9, 0, 0,                        1, 0, 'h30,    0, 0, 'h30,  'hFFFFFB,  0);
    vecs[5] = mk(16, 2, 5, 6, 0,                         0, 0, 'h1FFFF, 2, 1, 'h1,   11,        1);
    vecs[6] = mk(0,  1, 42, 0, 0,                        0, 0, 'h50,    0, 0, 'h50,  42,        0);
    vecs[7] = mk(1,  1, -1, 0, 0,                        31, 0, 'h60,   0, 0, 'h60,  'hFFFFFF,  0);
    vecs[8] = mk(9,  2, 3, 4, 0,                         0, 2, 'h70,    1, 0, 'h74,  7,         0);

    reset = 1'b1; pushin = 1'b0; sum_in = '0; neuron_table = '0; post_shift = '0;
    neuron_shift = '0; oloc = '0; ninputs = '0; neuron_number = '0; finish_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven neurons, including latency check on each write
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].nsum; k++) begin
        if (k == vecs[i].nsum - 1) expect_wr(vecs[i].eaddr, vecs[i].edata, vecs[i].efin);
        send(vecs[i].n_in, vecs[i].s[k], vecs[i].ps, vecs[i].ns, vecs[i].ol, vecs[i].nn, vecs[i].fin);
      end
      chk("wr_en_T+1", wr_en, 0);
      chk("stopout_scale", stopout, 1);
      @(posedge clk); #1;
      chk("wr_en_T+2", wr_en, 1);
      @(posedge clk); #1;
      chk("busy_after_write", busy, 0);
      drain();
    end
    chk("err_clean", err, 0);

    // Push held during SCALE: dropped, flagged, result unaffected
    expect_wr(4, 64, 0);
    send(8, 48'd64, 0, 0, 0, 4, 0);
    pushin = 1'b1; sum_in = 48'd999;
    #1;
    chk("stopout_in_scale", stopout, 1);
    @(posedge clk); #1;
    pushin = 1'b0;
    chk("err_push_in_scale", err, 1);
    drain();

    // Neuron switch mid-ACCUM: only the new neuron is written
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    chk("err_cleared", err, 0);
    send(20, 48'd100, 0, 0, 'h300, 5, 0);
    expect_wr('h306, 7, 0);
    send(8, 48'd7, 0, 0, 'h300, 6, 0);
    chk("err_mismatch", err, 1);
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Reset after 1 of 3 chunks, then a clean neuron flagged as layer end
    send(24, 48'd55, 0, 0, 'h10, 9, 0);
    chk("busy_accum", busy, 1);
    reset = 1'b1;
    #2;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    expect_wr('h12, 12, 1);
    send(8, 48'd12, 0, 0, 'h10, 2, 1);
    drain();

    // ReLU-dependent result for a negative sum, then a positive one
    expect_wr('h40, RELU ? 0 : 'hFFFFB0, 0);
    send(8, -48'sd80, 0, 0, 'h40, 0, 0);
    drain();
    expect_wr('h41, 80, 0);
    send(8, 48'd80, 0, 0, 'h40, 1, 0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("write_count", n_wr, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_result_accum.md
Name: nn_result_accum

Overview:
- Receiving end of the calc pushout/stopin interface. Consumes per-chunk partial sums (8 products each) together with neuron metadata.
- Accumulates all chunks of one neuron, applies PostShift and saturation, then issues one result write to activation memory at the neuron's output location.
- Drives calc's stopin. Emits done_from_rcalculator and a finish indication.

Parameters:
- SUM_W, 48, width of incoming partial sum (signed).
- ACC_W, 56, accumulator width (signed); covers up to 128 chunks without overflow.
- OUT_W, 24, result width written to memory (signed, matches input activation width).
- ADDR_W, 17, output address width.
- LANES, 8, products per chunk; must be a power of 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pushin  input  1  partial-sum valid (calc pushout)
- stopout  output  1  not-ready, to calc stopin
- sum_in  input  SUM_W  signed partial sum
- neuron_table  input  17  neuron table pointer (passed through, registered)
- post_shift  input  5  arithmetic right shift applied to final sum
- neuron_shift  input  5  log2 output stride
- oloc  input  ADDR_W  output base address
- ninputs  input  10  neuron fan-in
- neuron_number  input  11  neuron index
- finish_in  input  1  calc Finish_out (last neuron of layer)
- wr_en  output  1  result write strobe
- wr_addr  output  ADDR_W  result address
- wr_data  output  OUT_W  saturated result
- done  output  1  one-cycle pulse with wr_en (to calc done_from_rcalculator)
- finish_out  output  1  one-cycle pulse: last neuron of layer written
- busy  output  1  high when state != IDLE
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset: all outputs 0, state IDLE, acc 0, chunk count 0, metadata registers 0, err 0. Reset mid-operation discards any partial neuron; nothing is written.
- Chunk target: nchunks = max(1, ceil(ninputs/LANES)). Computed from the first packet of each neuron and latched.
- Accept: a packet is accepted when pushin=1 && stopout=0. stopout = (state==SCALE || state==WRITE), combinational.
- States:
  - IDLE: on accept, latch metadata and finish_in, set acc=sext(sum_in), cnt=1. Go to SCALE if nchunks==1, else ACCUM.
  - ACCUM: on accept with matching neuron_number, acc += sext(sum_in) and cnt++. When cnt reaches nchunks, go to SCALE.
  - SCALE (1 cycle): shifted = acc >>> post_shift (arithmetic). Saturate to OUT_W: value > 2^(OUT_W-1)-1 becomes 0x7FFFFF; value < -2^(OUT_W-1) becomes 0x800000. Register the result.
  - WRITE (1 cycle): wr_en=1, done=1. wr_addr = (oloc + (neuron_number << neuron_shift)) mod 2^ADDR_W. finish_out=1 if the latched finish was set. Next state is IDLE. Outputs are registered.
- Latency: last chunk accepted in cycle T; wr_en high in cycle T+2. Next packet can be accepted in T+3. Back-to-back packets in ACCUM are accepted every cycle.
- Neuron mismatch in ACCUM (accepted packet with a different neuron_number): set err, discard the partial, and restart as IDLE-accept with this packet.
- pushin while stopout=1: packet ignored, err set. The calc contract is to hold the packet.
- Accumulator wrap is not checked (ACC_W is sized for ninputs ≤ 1023).
- finish_in is sampled only on a neuron's first packet.

Optional Feature:
- NN_RELU_EN defined: after saturation in SCALE, negative results are forced to 0 (ReLU).
- Not defined: the signed saturated value is written unchanged.

Decomposition:
- Package nn_pkg: SUM_W/OUT_W/ADDR_W constants; a result-metadata packed struct (neuron_table, post_shift, neuron_shift, oloc, ninputs, neuron_number), shared with calc's outputs struct; state enum {IDLE, ACCUM, SCALE, WRITE}.
- One sub-module: nn_shift_sat. Combinational arithmetic shift, saturation and optional ReLU, reusable elsewhere in the datapath.

Test Plan:
- Single-chunk neuron. Stimulus: ninputs=8, sum_in=1000, post_shift=2, oloc=0x100, neuron_number=3, neuron_shift=1. Required: wr_en at T+2, wr_addr=0x106, wr_data=250, done pulse, finish_out=0.
- Three-chunk neuron. Stimulus: ninputs=20, back-to-back sums 100, -50, 30, post_shift=0. Required: one write with wr_data=80, no write before the third packet, stopout low during ACCUM.
- Saturation. Stimulus: sum_in=2^40, post_shift=0. Required: wr_data=0x7FFFFF. Stimulus: sum_in=-2^40. Required: 0x800000. Stimulus: sum_in=-9, post_shift=1. Required: -5 (arithmetic shift).
- Protocol violations:
  - pushin held during SCALE: stopout=1, packet dropped, err=1, written result unchanged.
  - neuron_number change mid-ACCUM: err=1, only the new neuron is written.
- Finish/reset:
  - finish_in=1 on the last neuron: finish_out pulses together with wr_en.
  - reset asserted after 1 of 3 chunks: no write, all outputs 0, next neuron is correct.
- NN_RELU_EN build, sums -80 then +80: written 0 then 80. Without the macro: -80 (0xFFFFB0), then 80.
